fsm_dispatch: RTL and testbench
===============================

Name: fsm_dispatch

Overview:
Top-level sequencer of the multicycle control unit. It fetches an instruction and latches it for the opcode decoder. It then pulses `start` to exactly one execution FSM (alu, load/store, branch, ...) and waits for that FSM's `done`. It is the initiator of the start/done handshake that every per-class FSM answers, and it traps on illegal decode, spurious done or a hung FSM.

Parameters:
- N_FSM, 8: number of execution FSMs; width of the `fsm_req`, `start_vec` and `done_vec` vectors.
- TIMEOUT, 64: maximum cycles spent in WAIT before a timeout trap; must be ≥ 2.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- run  in  1  level; allow fetching of new instructions
- imem_done  in  1  instruction memory read complete; `imem_rdata` is valid in the same cycle
- imem_rdata  in  32  fetched instruction word
- fsm_req  in  N_FSM  one-hot class select from the opdecoder, driven combinationally from `insn`
- done_vec  in  N_FSM  `done` lines of the execution FSMs
- trap_clear  in  1  pulse; leave TRAP
- fetch_start  out  1  one-cycle instruction memory read request
- insn  out  32  latched instruction, shared with the decoder and all execution FSMs
- start_vec  out  N_FSM  one-hot, one-cycle start pulse
- busy  out  1  high in every state except IDLE and TRAP
- trap  out  1  high while in TRAP
- trap_cause  out  2  0 none, 1 illegal, 2 spurious done, 3 timeout

Behaviour:
- Reset (asynchronous, active-high): state IDLE. All outputs 0, including `insn`, `start_vec` and `trap_cause`. Internal `sel` index and timeout counter are 0. Asserting reset mid-operation aborts immediately; no start pulse is issued after reset deasserts unless `run` is high.
- All outputs are registered; no combinational path from inputs to outputs.
- IDLE: when `run`=1, go to FETCH.
- FETCH:
  - `fetch_start`=1 only in the first cycle spent in FETCH.
  - Wait indefinitely for `imem_done` (no timeout).
  - On `imem_done`: `insn` <= `imem_rdata`; go to DECODE.
- DECODE: exactly one cycle, which lets the opdecoder settle on the new `insn`. `fsm_req` is sampled at the end of this cycle.
  - Exactly one bit set: `sel` <= index of that bit; go to START.
  - Zero bits or more than one bit set: `trap_cause` <= 1; go to TRAP.
- START: `start_vec`[`sel`]=1 for one cycle; timeout counter <= 0; go to WAIT.
- WAIT: the counter increments every cycle. Checks, in priority order:
  1. `done_vec`[`sel`]=1: instruction retired. Go to FETCH if `run`=1, otherwise to IDLE. `done` beats timeout in the same cycle.
  2. Any other `done_vec` bit set: `trap_cause` <= 2; go to TRAP. If `done_vec`[`sel`] is also set, the instruction retires and the extra bit is ignored.
  3. Counter = TIMEOUT-1: `trap_cause` <= 3; go to TRAP.
- TRAP:
  - `trap`=1; `trap_cause` holds its value.
  - `run` is ignored.
  - On `trap_clear`: `trap_cause` <= 0; go to IDLE.
  - `trap_clear` in any other state has no effect.
- Dropping `run` never aborts an instruction in flight; it only stops the next fetch.
- Latency: `run` high to `start_vec` pulse is 4 cycles when `imem_done` returns in the cycle after `fetch_start` (IDLE, FETCH×2, DECODE, START). Back-to-back instructions incur 3 cycles of overhead after `done`.
- Sub-FSM `start` inputs are sampled in their IDLE state, so a single-cycle pulse is sufficient.

Optional Feature:
- Macro: `DISPATCH_PERF_EN`.
- Defined:
  - Adds outputs `cycles[63:0]` and `instret[63:0]`, both reset to 0.
  - `cycles` increments every cycle in which `busy`=1.
  - `instret` increments on each retirement in WAIT.
  - Both wrap modulo 2^64 and freeze in TRAP.
- Not defined: the ports do not exist and no counter logic is synthesized.

Decomposition:
- Package `control_unit_pkg`:
  - state encodings: IDLE=3'b000, FETCH=3'b001, DECODE=3'b010, START=3'b011, WAIT=3'b100, TRAP=3'b111;
  - trap cause constants: CAUSE_NONE, CAUSE_ILLEGAL, CAUSE_SPURIOUS, CAUSE_TIMEOUT.
- One sub-module, `onehot_check`, parameterised by N: purely combinational. Outputs `valid` (exactly one bit set) and `index` of width $clog2(N). Reusable by the opdecoder.

Test Plan:
- Normal retire: `run`=1, `imem_done` one cycle after `fetch_start` with `imem_rdata`=0x00A50533, `fsm_req`=8'b0000_0001, `done_vec`[0] 2 cycles after `start_vec`=8'b0000_0001 -> `insn`=0x00A50533; next `fetch_start` 1 cycle after `done`; `trap`=0.
- Illegal decode: `fsm_req`=8'b0000_0000, then repeat with 8'b0001_0100 -> no `start_vec` pulse; `trap`=1, `trap_cause`=1; `trap_clear` -> IDLE, `trap_cause`=0.
- Timeout: selected `done` never arrives -> `trap`=1 exactly TIMEOUT=64 cycles after entering WAIT; `trap_cause`=3. Same run with `done` arriving on cycle 64 -> retire, no trap.
- Spurious done: `sel`=2, `done_vec`=8'b0000_1000 -> `trap_cause`=2. `done_vec`=8'b0000_1100 in one cycle -> retire, no trap.
- Reset mid-WAIT and `run` drop: assert reset in WAIT -> all outputs 0 asynchronously, before the next clock edge. Drop `run` during WAIT -> current instruction retires, then IDLE with `busy`=0.
- With `DISPATCH_PERF_EN`: 3 back-to-back instructions -> `instret`=3 and `cycles` equal to the busy-cycle count. Trap occurs -> both counters freeze.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared encodings for the multicycle control unit: dispatcher states and
// trap cause codes.
package control_unit_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    FETCH  = 3'b001,
    DECODE = 3'b010,
    START  = 3'b011,
    WAIT   = 3'b100,
    TRAP   = 3'b111
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_ILLEGAL  = 2'd1,
    CAUSE_SPURIOUS = 2'd2,
    CAUSE_TIMEOUT  = 2'd3
  } cause_t;

endpackage

// File: rtl/onehot_check.sv
// One-hot validator: flags a vector with exactly one bit set and reports the
// position of that bit. Purely combinational; also used by the opdecoder.
module onehot_check #(
  parameter int N = 8,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] vec,
  output logic         valid,
  output logic [W-1:0] index
);

  logic seen;
  logic multi;

  // Scan every bit: remember whether one was found and whether a second one followed.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // it unassigned and no latch is inferred.
    seen  = 1'b0;
    multi = 1'b0;
    index = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        if (seen) multi = 1'b1;
        seen  = 1'b1;
        index = W'(i);  // meaningful only when valid
      end
    end
    valid = seen && !multi;
  end

endmodule

// File: rtl/fsm_dispatch.sv
// Top-level sequencer of the multicycle control unit: fetch, latch the
// instruction, start one execution FSM and wait for its done; trap on illegal
// decode, spurious done or timeout.
// Optional build macro DISPATCH_PERF_EN adds cycles/instret counters.
module fsm_dispatch
  import control_unit_pkg::*;
#(
  parameter int N_FSM   = 8,
  parameter int TIMEOUT = 64   // must be >= 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             imem_done,
  input  logic [31:0]      imem_rdata,
  input  logic [N_FSM-1:0] fsm_req,
  input  logic [N_FSM-1:0] done_vec,
  input  logic             trap_clear,
  output logic             fetch_start,
  output logic [31:0]      insn,
  output logic [N_FSM-1:0] start_vec,
  output logic             busy,
  output logic             trap,
  output logic [1:0]       trap_cause
`ifdef DISPATCH_PERF_EN
  ,
  output logic [63:0]      cycles,
  output logic [63:0]      instret
`endif
);

  localparam int SEL_W = (N_FSM > 1) ? $clog2(N_FSM) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  state_t           state, state_next;
  cause_t           cause, cause_next;
  logic [SEL_W-1:0] sel, sel_next;
  logic [CNT_W-1:0] cnt;
  logic             req_valid;
  logic [SEL_W-1:0] req_index;
  logic [N_FSM-1:0] sel_mask;

  onehot_check #(.N(N_FSM)) u_req_check (
    .vec   (fsm_req),
    .valid (req_valid),
    .index (req_index)
  );

  assign sel_mask   = N_FSM'(1) << sel;
  assign trap_cause = cause;

  // Next-state, next-select and next-cause decision.
  always_comb begin
    state_next = state;
    cause_next = cause;
    sel_next   = sel;
    case (state)
      IDLE:   if (run) state_next = FETCH;
      FETCH:  if (imem_done) state_next = DECODE;
      DECODE: begin
        if (req_valid) begin
          sel_next   = req_index;
          state_next = START;
        end else begin
          cause_next = CAUSE_ILLEGAL;
          state_next = TRAP;
        end
      end
      START:  state_next = WAIT;
      WAIT: begin
        // The selected done wins over both a stray done and the timeout.
        if (|(done_vec & sel_mask)) begin
          state_next = run ? FETCH : IDLE;
        end else if (|(done_vec & ~sel_mask)) begin
          cause_next = CAUSE_SPURIOUS;
          state_next = TRAP;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          cause_next = CAUSE_TIMEOUT;
          state_next = TRAP;
        end
      end
      TRAP: begin
        if (trap_clear) begin
          cause_next = CAUSE_NONE;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, datapath and registered outputs; outputs are computed from the
  // next state so every output is a flop with no input-to-output path.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state       <= IDLE;
      cause       <= CAUSE_NONE;
      sel         <= '0;
      cnt         <= '0;
      insn        <= '0;
      fetch_start <= 1'b0;
      start_vec   <= '0;
      busy        <= 1'b0;
      trap        <= 1'b0;
    end else begin
      state <= state_next;
      cause <= cause_next;
      sel   <= sel_next;
      if (state == FETCH && imem_done) insn <= imem_rdata;
      if (state == START)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt + CNT_W'(1);
      fetch_start <= (state_next == FETCH) && (state != FETCH);
      start_vec   <= (state_next == START) ? (N_FSM'(1) << sel_next) : '0;
      busy        <= (state_next != IDLE) && (state_next != TRAP);
      trap        <= (state_next == TRAP);
    end
  end

`ifdef DISPATCH_PERF_EN
  logic retire;
  assign retire = (state == WAIT) && |(done_vec & sel_mask);

  // Performance counters; busy is low in TRAP, so both freeze there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycles  <= '0;
      instret <= '0;
    end else begin
      if (busy)   cycles  <= cycles + 64'd1;
      if (retire) instret <= instret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fsm_dispatch.sv
// Self-checking bench for fsm_dispatch. Expected start pulses are queued when
// the decode is driven and popped when start_vec fires.
`timescale 1ns/1ps
module tb_fsm_dispatch;

  localparam int N_FSM   = 8;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset, run, imem_done, trap_clear;
  logic [31:0] imem_rdata;
  logic [7:0]  fsm_req, done_vec;
  logic        fetch_start, busy, trap;
  logic [31:0] insn;
  logic [7:0]  start_vec;
  logic [1:0]  trap_cause;
`ifdef DISPATCH_PERF_EN
  logic [63:0] cycles, instret;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  fsm_dispatch #(.N_FSM(N_FSM), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .imem_done   (imem_done),
    .imem_rdata  (imem_rdata),
    .fsm_req     (fsm_req),
    .done_vec    (done_vec),
    .trap_clear  (trap_clear),
    .fetch_start (fetch_start),
    .insn        (insn),
    .start_vec   (start_vec),
    .busy        (busy),
    .trap        (trap),
    .trap_cause  (trap_cause)
`ifdef DISPATCH_PERF_EN
    ,
    .cycles      (cycles),
    .instret     (instret)
`endif
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic reset_dut;
    reset = 1'b1; run = 1'b0; imem_done = 1'b0; imem_rdata = '0;
    fsm_req = '0; done_vec = '0; trap_clear = 1'b0;
    exp_q.delete();
    tick; tick;
    reset = 1'b0;
  endtask

  // Entered at the negedge where fetch_start is high; returns at the negedge
  // of the cycle after DECODE (START or TRAP).
  task automatic fetch_decode(input logic [31:0] rdata, input logic [7:0] req);
    tick;
    n_checks++;
    if (fetch_start !== 1'b0) begin
      n_fail++; $display("FAIL fetch_start_once: got %b want 0", fetch_start);
    end
    imem_done = 1'b1; imem_rdata = rdata;
    tick;
    imem_done = 1'b0;
    n_checks++;
    if (insn !== rdata) begin
      n_fail++; $display("FAIL insn_latch: got %h want %h", insn, rdata);
    end
    fsm_req = req;
    if ($countones(req) == 1) exp_q.push_back(req);
    tick;
  endtask

  // Scoreboard pop: start_vec must match the oldest queued expectation.
  task automatic expect_start;
    logic [7:0] exp;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL start_unexpected: got %b want none", start_vec);
    end else begin
      exp = exp_q.pop_front();
      if (start_vec !== exp) begin
        n_fail++; $display("FAIL start_vec: got %b want %b", start_vec, exp);
      end
    end
  endtask

  // Entered at the START negedge; drives done bits after `delay` cycles.
  task automatic wait_done(input int delay, input logic [7:0] bits);
    repeat (delay) tick;
    done_vec = bits;
    tick;
    done_vec = '0;
  endtask

  task automatic clear_trap;
    run = 1'b0; trap_clear = 1'b1;
    tick;
    trap_clear = 1'b0;
  endtask

  task automatic test_reset;
    reset_dut;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({fetch_start, insn, start_vec, busy, trap, trap_cause} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got fs=%b insn=%h sv=%b busy=%b trap=%b cause=%0d want all 0",
                         fetch_start, insn, start_vec, busy, trap, trap_cause);
    end
    tick;
    reset = 1'b0;
    repeat (3) tick;
    n_checks++;
    if (busy !== 1'b0 || fetch_start !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_run: got busy=%b fs=%b want 0 0", busy, fetch_start);
    end
  endtask

  task automatic test_normal_retire;
    reset_dut;
    run = 1'b1;
    tick;
    n_checks++;
    if (fetch_start !== 1'b1) begin
      n_fail++; $display("FAIL first_fetch: got %b want 1", fetch_start);
    end
    fetch_decode(32'h00A50533, 8'b0000_0001);
    expect_start;
    trap_clear = 1'b1;            // must be ignored outside TRAP
    wait_done(2, 8'b0000_0001);
    trap_clear = 1'b0;
    n_checks++;
    if (fetch_start !== 1'b1 || trap !== 1'b0 || insn !== 32'h00A50533) begin
      n_fail++; $display("FAIL retire_refetch: got fs=%b trap=%b insn=%h want 1 0 00a50533",
                         fetch_start, trap, insn);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] reqs [3] = '{8'h01, 8'h04, 8'h80};
    reset_dut;
    run = 1'b1;
    tick;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (fetch_start !== 1'b1) begin
        n_fail++; $display("FAIL b2b_fetch%0d: got %b want 1", i, fetch_start);
      end
      fetch_decode(32'h1000_0000 + i, reqs[i]);
      expect_start;
      if (i == 2) run = 1'b0;
      wait_done(2, reqs[i]);
    end
    n_checks++;
    if (busy !== 1'b0 || fetch_start !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle: got busy=%b fs=%b want 0 0", busy, fetch_start);
    end
`ifdef DISPATCH_PERF_EN
    n_checks++;
    if (instret !== 64'd3 || cycles !== 64'd18) begin
      n_fail++; $display("FAIL perf_b2b: got instret=%0d cycles=%0d want 3 18", instret, cycles);
    end
    run = 1'b1;
    tick;
    fetch_decode(32'hDEAD_0000, 8'h00);
    repeat (5) tick;
    n_checks++;
    if (trap !== 1'b1 || instret !== 64'd3 || cycles !== 64'd21) begin
      n_fail++; $display("FAIL perf_freeze: got trap=%b instret=%0d cycles=%0d want 1 3 21",
                         trap, instret, cycles);
    end
`endif
  endtask

  task automatic test_illegal;
    logic [7:0] reqs [2] = '{8'b0000_0000, 8'b0001_0100};
    reset_dut;
    for (int i = 0; i < 2; i++) begin
      run = 1'b1;
      tick;
      fetch_decode(32'hBAD0_0000 + i, reqs[i]);
      n_checks++;
      if (trap !== 1'b1 || trap_cause !== 2'd1 || start_vec !== '0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL illegal%0d: got trap=%b cause=%0d sv=%b busy=%b want 1 1 0 0",
                           i, trap, trap_cause, start_vec, busy);
      end
      repeat (2) tick;            // run still high: must be ignored
      n_checks++;
      if (trap !== 1'b1 || fetch_start !== 1'b0) begin
        n_fail++; $display("FAIL trap_hold%0d: got trap=%b fs=%b want 1 0", i, trap, fetch_start);
      end
      clear_trap;
      n_checks++;
      if (trap !== 1'b0 || trap_cause !== 2'd0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL trap_clear%0d: got trap=%b cause=%0d busy=%b want 0 0 0",
                           i, trap, trap_cause, busy);
      end
    end
  endtask

  task automatic test_timeout;
    int n;
    reset_dut;
    run = 1'b1;
    tick;
    fetch_decode(32'h0000_0002, 8'h02);
    expect_start;
    n = 0;
    while (trap !== 1'b1 && n < 4 * TIMEOUT) begin
      tick;
      n++;
    end
    n_checks++;
    if (n != TIMEOUT + 1 || trap_cause !== 2'd3) begin
      n_fail++; $display("FAIL timeout: got cycles_from_start=%0d cause=%0d want %0d 3",
                         n, trap_cause, TIMEOUT + 1);
    end
    clear_trap;
    run = 1'b1;
    tick;
    fetch_decode(32'h0000_0003, 8'h02);
    expect_start;
    wait_done(TIMEOUT, 8'h02);    // done in the last WAIT cycle
    n_checks++;
    if (trap !== 1'b0 || fetch_start !== 1'b1) begin
      n_fail++; $display("FAIL done_at_limit: got trap=%b fs=%b want 0 1", trap, fetch_start);
    end
  endtask

  task automatic test_spurious;
    reset_dut;
    run = 1'b1;
    tick;
    fetch_decode(32'h0000_0004, 8'h04);
    expect_start;
    wait_done(1, 8'b0000_1000);
    n_checks++;
    if (trap !== 1'b1 || trap_cause !== 2'd2) begin
      n_fail++; $display("FAIL spurious: got trap=%b cause=%0d want 1 2", trap, trap_cause);
    end
    clear_trap;
    run = 1'b1;
    tick;
    fetch_decode(32'h0000_0005, 8'h04);
    expect_start;
    wait_done(1, 8'b0000_1100);
    n_checks++;
    if (trap !== 1'b0 || fetch_start !== 1'b1) begin
      n_fail++; $display("FAIL done_plus_extra: got trap=%b fs=%b want 0 1", trap, fetch_start);
    end
  endtask

  task automatic test_reset_and_run_drop;
    logic stray;
    reset_dut;
    run = 1'b1;
    tick;
    fetch_decode(32'h0000_0006, 8'h01);
    expect_start;
    tick; tick;                   // inside WAIT
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({fetch_start, insn, start_vec, busy, trap, trap_cause} !== '0) begin
      n_fail++; $display("FAIL async_reset: got fs=%b insn=%h sv=%b busy=%b trap=%b cause=%0d want all 0",
                         fetch_start, insn, start_vec, busy, trap, trap_cause);
    end
    run = 1'b0;
    tick;
    reset = 1'b0;
    stray = 1'b0;
    repeat (4) begin
      tick;
      if (start_vec !== '0 || fetch_start !== 1'b0 || busy !== 1'b0) stray = 1'b1;
    end
    n_checks++;
    if (stray !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_quiet: got activity=%b want 0", stray);
    end
    run = 1'b1;
    tick;
    fetch_decode(32'h0000_0007, 8'h10);
    expect_start;
    tick;
    run = 1'b0;                   // must not abort the instruction in flight
    wait_done(1, 8'h10);
    n_checks++;
    if (busy !== 1'b0 || fetch_start !== 1'b0 || trap !== 1'b0) begin
      n_fail++; $display("FAIL run_drop: got busy=%b fs=%b trap=%b want 0 0 0", busy, fetch_start, trap);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset;
    test_normal_retire;
    test_back_to_back;
    test_illegal;
    test_timeout;
    test_spurious;
    test_reset_and_run_drop;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
